// File: rtl/axis_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pack_pkg
//  Description : Shared types and helper functions for the AXI-Stream byte
//                packing / keep-stripping blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_pack_pkg;

    typedef logic [7:0] byte_t;

    // Number of set bits in a keep vector (callers zero-extend to 64 bits).
    function automatic int unsigned popcount(input logic [63:0] keep);
        int unsigned n;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            n += 32'(keep[k]);
        end
        return n;
    endfunction

    // Width of a counter able to hold the values 0..bytes inclusive.
    function automatic int cnt_w(input int bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_keep_compactor.sv
`default_nettype none
// ============================================================================
//  Module      : axis_keep_compactor
//  Description : Combinational keep compactor. Gathers the kept byte lanes of
//                one beat into the low lanes, in ascending lane order, and
//                reports how many bytes were kept. Unused upper lanes are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_keep_compactor
    import axis_pack_pkg::*;
#(
    parameter int N_IN = 5
) (
    input  logic [8*N_IN-1:0]        i_tdata,
    input  logic [N_IN-1:0]          i_tkeep,
    output logic [8*N_IN-1:0]        o_data,
    output logic [cnt_w(N_IN)-1:0]   o_cnt
);

    localparam int c_CW = cnt_w(N_IN);

    // Walk the lanes in order and drop each kept byte into the next free slot.
    always_comb begin
        int w_pos;
        byte_t w_byte;
        o_data = '0;
        w_pos  = 0;
        w_byte = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (i_tkeep[k]) begin
                w_byte = i_tdata[8*k +: 8];
                o_data[8*w_pos +: 8] = w_byte;
                w_pos = w_pos + 1;
            end
        end
    end

    assign o_cnt = c_CW'(popcount(64'(i_tkeep)));

endmodule
`default_nettype wire

// File: rtl/axis_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_byte_packer
//  Description : AXI-Stream byte packer with independent input/output widths.
//                Null bytes are dropped, kept bytes are compacted in order and
//                emitted as dense N_OUT-byte beats. tlast flushes a partial
//                final beat; an all-null packet still yields one tlast beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_byte_packer
    import axis_pack_pkg::*;
#(
    parameter int N_IN      = 5,
    parameter int N_OUT     = 5,
    // Must be at least N_IN+N_OUT-1 so a stalled partial beat never deadlocks.
    parameter int BUF_BYTES = N_IN + N_OUT
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [8*N_IN-1:0]    in_tdata,
    input  logic [N_IN-1:0]      in_tkeep,
    input  logic                 in_tlast,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    output logic [8*N_OUT-1:0]   out_tdata,
    output logic [N_OUT-1:0]     out_tkeep,
    output logic                 out_tlast,
    output logic                 out_tvalid,
    input  logic                 out_tready
);

    localparam int c_CW = cnt_w(BUF_BYTES);
    localparam int c_IW = cnt_w(N_IN);
    localparam logic [c_CW-1:0] c_N_OUT = c_CW'(N_OUT);

    logic [8*N_IN-1:0]      w_cmp_data;
    logic [c_IW-1:0]        w_cmp_cnt;

    logic [8*BUF_BYTES-1:0] r_buf;
    logic [8*BUF_BYTES-1:0] w_buf_nxt;
    logic [8*BUF_BYTES-1:0] w_app;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic [c_CW-1:0]        w_cnt_rem;
    logic [c_CW-1:0]        w_loaded;
    logic                   r_flush;
    logic                   w_flush_nxt;
    logic                   r_in_tready;
    logic                   w_ready_nxt;

    logic                   w_accept;
    logic                   w_out_free;
    logic                   w_load_full;
    logic                   w_load_flush;
    logic                   w_last_load;
    logic [N_OUT-1:0]       w_out_keep;

    logic [8*N_OUT-1:0]     r_out_tdata;
    logic [N_OUT-1:0]       r_out_tkeep;
    logic                   r_out_tlast;
    logic                   r_out_tvalid;

    axis_keep_compactor #(
        .N_IN    (N_IN)
    ) u_compactor (
        .i_tdata (in_tdata),
        .i_tkeep (in_tkeep),
        .o_data  (w_cmp_data),
        .o_cnt   (w_cmp_cnt)
    );

    // Next-state for buffer, count, flush flag and the registered ready.
    always_comb begin
        w_accept     = in_tvalid & r_in_tready;
        w_out_free   = ~r_out_tvalid | out_tready;
        w_load_full  = w_out_free & (r_cnt >= c_N_OUT);
        // Covers the empty-packet case too: count may be 0 here.
        w_load_flush = w_out_free & r_flush & (r_cnt < c_N_OUT);
        w_last_load  = w_load_flush | (w_load_full & r_flush & (r_cnt == c_N_OUT));

        if (w_load_full) begin
            w_loaded = c_N_OUT;
        end else if (w_load_flush) begin
            w_loaded = r_cnt;
        end else begin
            w_loaded = '0;
        end

        w_app = '0;
        if (w_accept) begin
            w_app[8*N_IN-1:0] = w_cmp_data;
        end

        // Bytes above count are always zero, so drain-then-OR appends cleanly.
        w_cnt_rem = r_cnt - w_loaded;
        w_buf_nxt = (r_buf >> (8 * int'(w_loaded))) | (w_app << (8 * int'(w_cnt_rem)));
        w_cnt_nxt = w_cnt_rem + (w_accept ? c_CW'(w_cmp_cnt) : '0);

        if (w_accept & in_tlast) begin
            w_flush_nxt = 1'b1;
        end else if (w_last_load) begin
            w_flush_nxt = 1'b0;
        end else begin
            w_flush_nxt = r_flush;
        end

        w_ready_nxt = ~w_flush_nxt & ((int'(w_cnt_nxt) + N_IN) <= BUF_BYTES);

        for (int k = 0; k < N_OUT; k++) begin
            w_out_keep[k] = w_load_full | (k < int'(r_cnt));
        end
    end

    // Staging buffer, byte count, packet-flush flag and input ready.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_flush     <= 1'b0;
            r_in_tready <= 1'b0;
        end else begin
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_flush     <= w_flush_nxt;
            r_in_tready <= w_ready_nxt;
        end
    end

    // Output register: loads a full or flush beat whenever it is free.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_out_tdata  <= '0;
            r_out_tkeep  <= '0;
            r_out_tlast  <= 1'b0;
            r_out_tvalid <= 1'b0;
        end else if (w_load_full | w_load_flush) begin
            r_out_tdata  <= r_buf[8*N_OUT-1:0];
            r_out_tkeep  <= w_out_keep;
            r_out_tlast  <= w_last_load;
            r_out_tvalid <= 1'b1;
        end else if (out_tready) begin
            r_out_tvalid <= 1'b0;
        end
    end

    assign in_tready  = r_in_tready;
    assign out_tdata  = r_out_tdata;
    assign out_tkeep  = r_out_tkeep;
    assign out_tlast  = r_out_tlast;
    assign out_tvalid = r_out_tvalid;

endmodule
`default_nettype wire

// File: doc/axis_byte_packer.md
Name: axis_byte_packer

Overview:
AXI-Stream byte packer with independent input and output widths. Null bytes (tkeep=0) are dropped, valid bytes are compacted in order, and dense N_OUT-byte beats are emitted. Unlike the fixed-width packer, it carries packet boundaries: tlast flushes a partial final beat, with out_tkeep and out_tlast set. It sits between framing/strip logic that punches holes in tkeep and downstream width-converting datapaths.

Parameters:
N_IN, 5, input bytes per beat (>=1)
N_OUT, 5, output bytes per beat (>=1)
BUF_BYTES, N_IN+N_OUT, staging buffer depth in bytes (must be >= N_IN+N_OUT-1)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
in_tdata  in  8*N_IN  input bytes; lane k = bits [8k+7:8k]; lane 0 is first in stream order
in_tkeep  in  N_IN  per-lane byte valid; any pattern allowed, including 0 and non-contiguous
in_tlast  in  1  last beat of packet
in_tvalid  in  1  input valid
in_tready  out  1  input ready
out_tdata  out  8*N_OUT  packed bytes; lane 0 is first
out_tkeep  out  N_OUT  all-ones except on a flush beat: contiguous low lanes, possibly 0
out_tlast  out  1  last beat of packet
out_tvalid  out  1  output valid
out_tready  in  1  output ready

Behaviour:
- Clock aclk; reset aresetn, synchronous, active-low.
- Reset values: out_tvalid=0, out_tdata=0, out_tkeep=0, out_tlast=0, in_tready=0, buffer count=0, flush_pending=0. in_tready rises the first cycle after reset release.
- Reset mid-packet discards all buffered bytes and any held output beat. There is no partial emission.
- Accept on in_tvalid&in_tready. Kept lanes are appended to the buffer in ascending lane order. Popcount(in_tkeep) bytes are added to count.
- in_tready comes from registered state only, with no combinational path from out_tready: in_tready = ~flush_pending & (count + N_IN <= BUF_BYTES).
- The output register is a full registered stage. It loads when (~out_tvalid | out_tready) and one of these holds:
  - count >= N_OUT: take the oldest N_OUT bytes; out_tkeep=all-ones. out_tlast=1 only if this empties the buffer and flush_pending=1.
  - flush_pending and 0 < count < N_OUT: take all bytes into the low lanes. out_tkeep=(1<<count)-1, out_tlast=1, upper lanes of out_tdata=0.
- Accepting in_tlast sets flush_pending. flush_pending clears when the out_tlast beat loads.
- Empty packet: in_tlast with popcount(in_tkeep)=0 and count=0 at flush time emits one beat with out_tkeep=0, out_tlast=1, out_tdata=0. Packet boundaries are never lost.
- Bytes never merge across packets: in_tready=0 while flush_pending=1.
- An accept and an output load in the same cycle are allowed. Count update = count + popcount − bytes_loaded.
- Bytes accepted in cycle t can appear on out_tdata no earlier than cycle t+1.
- The output holds stable (data, keep, last, valid) while out_tvalid & ~out_tready.
- Throughput: with N_IN==N_OUT, all-ones tkeep and out_tready=1, one beat per cycle in steady state.
- Count width = $clog2(BUF_BYTES+1). Arithmetic must not overflow at BUF_BYTES.

Decomposition:
- Package axis_pack_pkg holds:
  - function popcount(keep)
  - function cnt_w(bytes) returning $clog2(bytes+1)
  - a byte_t typedef (logic [7:0])
- Sub-module axis_keep_compactor (combinational): maps in_tdata/in_tkeep to a left-justified byte vector plus a byte count. It is reused by other strip blocks.
- The top module holds the byte buffer (shift-based), count, flush_pending and the output register.

Test Plan:
1. N_IN=N_OUT=5, 4 beats all-keep, bytes 0x00..0x13, out_tready=1, tlast on beat 4 -> 4 out beats identical to the input, out_tkeep=5'h1F, out_tlast on beat 4 only, one beat/cycle after 1-cycle latency.
2. N_IN=5, in_tkeep=5'b10101 ×5 beats (bytes A0,A2,A4 per beat), tlast on beat 5 -> 15 bytes packed into 3 full beats in order; last beat has out_tlast=1, out_tkeep=5'h1F.
3. N_IN=4, N_OUT=8, 3 full beats 0x00..0x0B with tlast -> beat1 bytes 0x00..0x07 keep 8'hFF tlast=0; beat2 bytes 0x08..0x0B keep 8'h0F tlast=1, upper lanes 0.
4. Empty packet: single beat tkeep=0 tlast=1 with buffer empty -> one out beat tkeep=0 tlast=1; next packet's bytes are not merged into it.
5. Backpressure: out_tready=0 for 10 cycles during a stream -> out_* stable, in_tready drops once count+N_IN>BUF_BYTES, no byte lost or duplicated after release (scoreboard).
6. Reset asserted with 3 bytes buffered and out_tvalid=1 -> next cycle out_tvalid=0, count=0; the next packet emits only its own bytes.
